// File: rtl/wash_controller.sv
// wash_controller: wash-cycle sequencer driving the timer, with pause, extra pass and watchdog
module wash_controller #(
  parameter logic [31:0] WDOG_LIMIT = 32'd0,
  parameter bit          EXTRA_PASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       pause_req,
  input  logic       timer_done,
  output logic [2:0] state_out,
  output logic       start_timer,
  output logic       busy,
  output logic       wash_done,
  output logic       fault
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    PAUSE = 3'd5
  } state_t;
  state_t      state, saved;
  logic        extra;
  logic [31:0] wdog, wdog_n;
  logic        done, wdog_hit;
  assign state_out = state;
  // timer_done is blind during the start cycle; watchdog saturates and trips on reaching the limit
  always_comb begin
    done     = timer_done & ~start_timer;
    wdog_n   = &wdog ? wdog : wdog + 32'd1;
    wdog_hit = (WDOG_LIMIT != 32'd0) && (wdog_n >= WDOG_LIMIT);
  end
  // sequencing FSM with registered outputs; done beats watchdog beats pause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      saved       <= IDLE;
      extra       <= 1'b0;
      wdog        <= '0;
      start_timer <= 1'b0;
      busy        <= 1'b0;
      wash_done   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      start_timer <= 1'b0;
      wash_done   <= 1'b0;
      case (state)
        IDLE: if (coin_in) begin
          state       <= FILL;
          start_timer <= 1'b1;
          busy        <= 1'b1;
          extra       <= double_wash & EXTRA_PASS;
          fault       <= 1'b0;
          wdog        <= '0;
        end
        FILL, WASH, RINSE, SPIN: if (done) begin
          state       <= state == FILL ? WASH : state == WASH ? RINSE :
                         state == RINSE ? (extra ? WASH : SPIN) : IDLE;
          start_timer <= state != SPIN;
          busy        <= state != SPIN;
          wash_done   <= state == SPIN;
          extra       <= state == RINSE ? 1'b0 : extra;
          wdog        <= '0;
        end else if (wdog_hit) begin
          state <= IDLE;
          busy  <= 1'b0;
          fault <= 1'b1;
          wdog  <= wdog_n;
        end else begin
          wdog  <= wdog_n;
          saved <= pause_req ? state : saved;
          state <= pause_req ? PAUSE : state;
        end
        PAUSE: if (!pause_req) state <= saved;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wash_controller.sv
// tb_wash_controller: directed tests of the wash sequencer across three parameterisations
module tb_wash_controller;
  logic clk = 1'b0, rst = 1'b0, coin = 1'b0, dbl = 1'b0, pause = 1'b0, td_man = 1'b0, auto_m = 1'b0, clr = 1'b0;
  logic [2:0] st_m, st_n, st_w;
  logic start_m, busy_m, done_m, fault_m;
  logic start_n, busy_n, done_n, fault_n;
  logic start_w, busy_w, done_w, fault_w;
  logic tda_m = 1'b0, tda_n = 1'b0;
  int cd_m = 0, cd_n = 0;
  logic [31:0] log_m = 1, log_n = 1;
  logic [2:0] prev_m = 3'd0, prev_n = 3'd0;
  int starts_m = 0, dones_m = 0, starts_n = 0, dones_n = 0, dones_w = 0;
  int n_cmp = 0, n_bad = 0;
  int snap;

  always #5 clk = ~clk;

  wash_controller dut (.clk(clk), .rst(rst), .coin_in(coin), .double_wash(dbl), .pause_req(pause),
    .timer_done(auto_m ? tda_m : td_man), .state_out(st_m), .start_timer(start_m), .busy(busy_m),
    .wash_done(done_m), .fault(fault_m));
  wash_controller #(.WDOG_LIMIT(32'd0), .EXTRA_PASS(1'b0)) dut_np (.clk(clk), .rst(rst), .coin_in(coin),
    .double_wash(dbl), .pause_req(pause), .timer_done(tda_n), .state_out(st_n), .start_timer(start_n),
    .busy(busy_n), .wash_done(done_n), .fault(fault_n));
  wash_controller #(.WDOG_LIMIT(32'd20), .EXTRA_PASS(1'b1)) dut_wd (.clk(clk), .rst(rst), .coin_in(coin),
    .double_wash(dbl), .pause_req(pause), .timer_done(1'b0), .state_out(st_w), .start_timer(start_w),
    .busy(busy_w), .wash_done(done_w), .fault(fault_w));

  // timer stand-ins: Finished pulses three cycles after each start pulse
  always @(negedge clk) begin
    if (rst) begin
      cd_m <= 0; tda_m <= 1'b0; cd_n <= 0; tda_n <= 1'b0;
    end else begin
      tda_m <= 1'b0;
      tda_n <= 1'b0;
      if (start_m) cd_m <= 3;
      else if (cd_m != 0) begin cd_m <= cd_m - 1; if (cd_m == 1) tda_m <= 1'b1; end
      if (start_n) cd_n <= 3;
      else if (cd_n != 0) begin cd_n <= cd_n - 1; if (cd_n == 1) tda_n <= 1'b1; end
    end
  end

  // state-change log (one octal digit per visited state, leading 1 as marker) and pulse counters
  always @(negedge clk) begin
    if (clr) begin
      log_m <= 1; prev_m <= st_m; starts_m <= 0; dones_m <= 0;
      log_n <= 1; prev_n <= st_n; starts_n <= 0; dones_n <= 0; dones_w <= 0;
    end else begin
      if (st_m != prev_m) log_m <= {log_m[28:0], st_m};
      if (st_n != prev_n) log_n <= {log_n[28:0], st_n};
      prev_m <= st_m;
      prev_n <= st_n;
      if (start_m) starts_m <= starts_m + 1;
      if (done_m) dones_m <= dones_m + 1;
      if (start_n) starts_n <= starts_n + 1;
      if (done_n) dones_n <= dones_n + 1;
      if (done_w) dones_w <= dones_w + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; coin = 1'b0; dbl = 1'b0; pause = 1'b0; td_man = 1'b0; auto_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_done();
    repeat (2) @(negedge clk);
    td_man = 1'b1;
    @(negedge clk);
    td_man = 1'b0;
  endtask

  task automatic coin_once(input logic d);
    @(negedge clk);
    coin = 1'b1; dbl = d;
    @(negedge clk);
    coin = 1'b0; dbl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if ({st_m, start_m, busy_m, done_m, fault_m} !== 7'd0) begin n_bad++; $display("FAIL reset_main got=%b want=0", {st_m, start_m, busy_m, done_m, fault_m}); end
    n_cmp++; if ({st_w, start_w, busy_w, done_w, fault_w} !== 7'd0) begin n_bad++; $display("FAIL reset_wd got=%b want=0", {st_w, start_w, busy_w, done_w, fault_w}); end
    do_reset();
    n_cmp++; if (st_m !== 3'd0 || busy_m !== 1'b0) begin n_bad++; $display("FAIL reset_release state=%0d busy=%b want 0/0", st_m, busy_m); end
  endtask

  task automatic test_single_wash();
    do_reset();
    auto_m = 1'b1;
    clear_logs();
    coin_once(1'b0);
    repeat (40) @(negedge clk);
    n_cmp++; if (log_m !== 32'o112340) begin n_bad++; $display("FAIL single_seq got=%o want=112340", log_m); end
    n_cmp++; if (starts_m !== 4) begin n_bad++; $display("FAIL single_starts got=%0d want=4", starts_m); end
    n_cmp++; if (dones_m !== 1) begin n_bad++; $display("FAIL single_wash_done got=%0d want=1", dones_m); end
    n_cmp++; if (st_m !== 3'd0 || busy_m !== 1'b0) begin n_bad++; $display("FAIL single_end state=%0d busy=%b want 0/0", st_m, busy_m); end
  endtask

  task automatic test_double_wash();
    do_reset();
    auto_m = 1'b1;
    clear_logs();
    coin_once(1'b1);
    repeat (40) @(negedge clk);
    n_cmp++; if (log_m !== 32'o11232340) begin n_bad++; $display("FAIL double_seq got=%o want=11232340", log_m); end
    n_cmp++; if (starts_m !== 6) begin n_bad++; $display("FAIL double_starts got=%0d want=6", starts_m); end
    n_cmp++; if (dones_m !== 1) begin n_bad++; $display("FAIL double_wash_done got=%0d want=1", dones_m); end
    n_cmp++; if (log_n !== 32'o112340) begin n_bad++; $display("FAIL noextra_seq got=%o want=112340", log_n); end
    n_cmp++; if (starts_n !== 4 || dones_n !== 1) begin n_bad++; $display("FAIL noextra_counts starts=%0d done=%0d want 4/1", starts_n, dones_n); end
  endtask

  task automatic test_pause();
    do_reset();
    clear_logs();
    coin_once(1'b0);
    pulse_done();
    n_cmp++; if (st_m !== 3'd2 || start_m !== 1'b1) begin n_bad++; $display("FAIL pause_enter_wash state=%0d start=%b want 2/1", st_m, start_m); end
    pause = 1'b1;
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd5) begin n_bad++; $display("FAIL pause_state got=%0d want=5", st_m); end
    snap = starts_m;
    repeat (9) @(negedge clk);
    n_cmp++; if (st_m !== 3'd5 || busy_m !== 1'b1) begin n_bad++; $display("FAIL pause_hold state=%0d busy=%b want 5/1", st_m, busy_m); end
    pause = 1'b0;
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd2 || start_m !== 1'b0) begin n_bad++; $display("FAIL pause_resume state=%0d start=%b want 2/0", st_m, start_m); end
    n_cmp++; if (starts_m !== snap) begin n_bad++; $display("FAIL pause_no_start starts=%0d want=%0d", starts_m, snap); end
    td_man = 1'b1;
    @(negedge clk);
    td_man = 1'b0;
    n_cmp++; if (st_m !== 3'd3 || start_m !== 1'b1) begin n_bad++; $display("FAIL pause_then_done state=%0d start=%b want 3/1", st_m, start_m); end
  endtask

  task automatic test_handshake();
    do_reset();
    coin_once(1'b0);
    td_man = 1'b1;
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd1 || start_m !== 1'b0) begin n_bad++; $display("FAIL hs_ignore_start state=%0d start=%b want 1/0", st_m, start_m); end
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd2 || start_m !== 1'b1) begin n_bad++; $display("FAIL hs_advance state=%0d start=%b want 2/1", st_m, start_m); end
    @(negedge clk);
    td_man = 1'b0;
    n_cmp++; if (st_m !== 3'd2) begin n_bad++; $display("FAIL hs_hold_wash got=%0d want=2", st_m); end
    td_man = 1'b1; pause = 1'b1;
    @(negedge clk);
    td_man = 1'b0;
    n_cmp++; if (st_m !== 3'd3 || start_m !== 1'b1) begin n_bad++; $display("FAIL hs_done_beats_pause state=%0d start=%b want 3/1", st_m, start_m); end
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd5) begin n_bad++; $display("FAIL hs_pause_after got=%0d want=5", st_m); end
    pause = 1'b0;
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd3 || start_m !== 1'b0) begin n_bad++; $display("FAIL hs_resume_rinse state=%0d start=%b want 3/0", st_m, start_m); end
  endtask

  task automatic test_coin_pause();
    do_reset();
    @(negedge clk);
    coin = 1'b1; pause = 1'b1;
    @(negedge clk);
    coin = 1'b0;
    n_cmp++; if (st_m !== 3'd1 || start_m !== 1'b1) begin n_bad++; $display("FAIL coinpause_accept state=%0d start=%b want 1/1", st_m, start_m); end
    @(negedge clk);
    pause = 1'b0;
    n_cmp++; if (st_m !== 3'd5) begin n_bad++; $display("FAIL coinpause_pause got=%0d want=5", st_m); end
  endtask

  task automatic test_watchdog();
    do_reset();
    clear_logs();
    coin_once(1'b0);
    repeat (19) @(negedge clk);
    n_cmp++; if (st_w !== 3'd1 || fault_w !== 1'b0) begin n_bad++; $display("FAIL wd_before state=%0d fault=%b want 1/0", st_w, fault_w); end
    @(negedge clk);
    n_cmp++; if (st_w !== 3'd0 || fault_w !== 1'b1 || busy_w !== 1'b0) begin n_bad++; $display("FAIL wd_trip state=%0d fault=%b busy=%b want 0/1/0", st_w, fault_w, busy_w); end
    repeat (5) @(negedge clk);
    n_cmp++; if (fault_w !== 1'b1 || dones_w !== 0) begin n_bad++; $display("FAIL wd_sticky fault=%b wash_done=%0d want 1/0", fault_w, dones_w); end
    n_cmp++; if (fault_m !== 1'b0 || st_m !== 3'd1) begin n_bad++; $display("FAIL wd_disabled fault=%b state=%0d want 0/1", fault_m, st_m); end
    coin_once(1'b0);
    n_cmp++; if (fault_w !== 1'b0 || st_w !== 3'd1) begin n_bad++; $display("FAIL wd_coin_clear fault=%b state=%0d want 0/1", fault_w, st_w); end
  endtask

  task automatic test_async_reset();
    do_reset();
    coin_once(1'b0);
    pulse_done();
    pulse_done();
    n_cmp++; if (st_m !== 3'd3) begin n_bad++; $display("FAIL arst_in_rinse got=%0d want=3", st_m); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({st_m, start_m, busy_m, done_m, fault_m} !== 7'd0) begin n_bad++; $display("FAIL arst_immediate got=%b want=0", {st_m, start_m, busy_m, done_m, fault_m}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (st_m !== 3'd0 || busy_m !== 1'b0) begin n_bad++; $display("FAIL arst_idle state=%0d busy=%b want 0/0", st_m, busy_m); end
    coin_once(1'b0);
    n_cmp++; if (st_m !== 3'd1 || start_m !== 1'b1) begin n_bad++; $display("FAIL arst_restart state=%0d start=%b want 1/1", st_m, start_m); end
  endtask

  initial begin
    test_reset();
    test_single_wash();
    test_double_wash();
    test_pause();
    test_handshake();
    test_coin_pause();
    test_watchdog();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
